// File: rtl/kbd_text_ctrl.sv
// kbd_text_ctrl: pops scan codes from the PS/2 receive FIFO, tracks make,
// break and E0 prefixes, counts distinct key presses, and turns printable
// make codes into character-buffer writes at a managed text cursor.
module kbd_text_ctrl #(
    parameter int COLS = 70,
    parameter int ROWS = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] ps2_data,
    input  logic       ps2_ready,
    input  logic       ps2_overflow,
    output logic       ps2_nextdata_n,
    output logic [7:0] scan_code,
    input  logic [7:0] ascii_in,
    output logic       wr_en,
    output logic [4:0] wr_row,
    output logic [6:0] wr_col,
    output logic [7:0] wr_char,
    output logic [4:0] cur_row,
    output logic [6:0] cur_col,
    output logic       key_down,
    output logic [7:0] last_code,
    output logic [7:0] press_count,
    output logic       overflow_seen
);

    localparam logic [6:0] COL_LAST   = 7'(COLS - 1);
    localparam logic [4:0] ROW_LAST   = 5'(ROWS - 1);
    localparam logic [7:0] CODE_BRK   = 8'hF0;
    localparam logic [7:0] CODE_EXT   = 8'hE0;
    localparam logic [7:0] CODE_ENTER = 8'h5A;
    localparam logic [7:0] CODE_BKSP  = 8'h66;
    localparam logic [7:0] CHAR_SPACE = 8'h20;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_POP    = 2'd1,
        S_DECODE = 2'd2,
        S_WRITE  = 2'd3
    } state_t;

    // Next row with wrap to the top; the screen never scrolls.
    function automatic logic [4:0] row_next(input logic [4:0] row);
        if (row == ROW_LAST) begin
            row_next = 5'd0;
        end else begin
            row_next = row + 5'd1;
        end
    endfunction

    // Cursor position after a printed character, packed as {row, col}.
    function automatic logic [11:0] cur_advance(input logic [4:0] row, input logic [6:0] col);
        if (col < COL_LAST) begin
            cur_advance = {row, col + 7'd1};
        end else begin
            cur_advance = {row_next(row), 7'd0};
        end
    endfunction

    // Cursor position after a backspace step; (0,0) is a hard stop.
    function automatic logic [11:0] cur_back(input logic [4:0] row, input logic [6:0] col);
        if (col > 7'd0) begin
            cur_back = {row, col - 7'd1};
        end else if (row > 5'd0) begin
            cur_back = {row - 5'd1, COL_LAST};
        end else begin
            cur_back = {row, col};
        end
    endfunction

    state_t     state_q, state_d;
    logic [7:0] code_q, code_d;
    logic       brk_q, brk_d;
    logic       ext_q, ext_d;
    logic       nextdata_n_q, nextdata_n_d;
    logic       wr_en_q, wr_en_d;
    logic [4:0] wr_row_q, wr_row_d;
    logic [6:0] wr_col_q, wr_col_d;
    logic [7:0] wr_char_q, wr_char_d;
    logic [4:0] cur_row_q, cur_row_d;
    logic [6:0] cur_col_q, cur_col_d;
    logic       key_down_q, key_down_d;
    logic [7:0] last_code_q, last_code_d;
    logic [7:0] press_count_q, press_count_d;
    logic       overflow_q, overflow_d;
    logic [11:0] adv_s;
    logic [11:0] back_s;

    assign adv_s  = cur_advance(cur_row_q, cur_col_q);
    assign back_s = cur_back(cur_row_q, cur_col_q);

    // Next-state, decode and character action for the pop/decode/write sequence.
    always_comb begin
        state_d       = state_q;
        code_d        = code_q;
        brk_d         = brk_q;
        ext_d         = ext_q;
        nextdata_n_d  = 1'b1;
        wr_en_d       = 1'b0;
        wr_row_d      = wr_row_q;
        wr_col_d      = wr_col_q;
        wr_char_d     = wr_char_q;
        cur_row_d     = cur_row_q;
        cur_col_d     = cur_col_q;
        key_down_d    = key_down_q;
        last_code_d   = last_code_q;
        press_count_d = press_count_q;
        overflow_d    = overflow_q | ps2_overflow;

        case (state_q)
            S_IDLE: begin
                if (ps2_ready) begin
                    code_d       = ps2_data;
                    nextdata_n_d = 1'b0;   // low for exactly the POP cycle
                    state_d      = S_POP;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_POP: begin
                state_d = S_DECODE;
            end
            S_DECODE: begin
                state_d = S_IDLE;
                if (code_q == CODE_BRK) begin
                    brk_d = 1'b1;
                end else if (code_q == CODE_EXT) begin
                    ext_d = 1'b1;
                end else if (brk_q) begin
                    // Release: only the held key's break drops key_down.
                    if (code_q == last_code_q) begin
                        key_down_d = 1'b0;
                    end else begin
                        key_down_d = key_down_q;
                    end
                    brk_d = 1'b0;
                    ext_d = 1'b0;
                end else begin
                    ext_d = 1'b0;
                    // A make of the still-held key is typematic and not counted.
                    if (key_down_q && (code_q == last_code_q)) begin
                        press_count_d = press_count_q;
                    end else begin
                        press_count_d = press_count_q + 8'd1;
                        last_code_d   = code_q;
                        key_down_d    = 1'b1;
                    end
                    if (!ext_q) begin
                        if (code_q == CODE_ENTER) begin
                            cur_col_d = 7'd0;
                            cur_row_d = row_next(cur_row_q);
                        end else if (code_q == CODE_BKSP) begin
                            cur_row_d = back_s[11:7];
                            cur_col_d = back_s[6:0];
                            wr_row_d  = back_s[11:7];
                            wr_col_d  = back_s[6:0];
                            wr_char_d = CHAR_SPACE;
                            wr_en_d   = 1'b1;
                            state_d   = S_WRITE;
                        end else if (ascii_in != 8'd0) begin
                            wr_row_d  = cur_row_q;
                            wr_col_d  = cur_col_q;
                            wr_char_d = ascii_in;
                            cur_row_d = adv_s[11:7];
                            cur_col_d = adv_s[6:0];
                            wr_en_d   = 1'b1;
                            state_d   = S_WRITE;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_WRITE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; rst returns everything to idle at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            code_q        <= 8'd0;
            brk_q         <= 1'b0;
            ext_q         <= 1'b0;
            nextdata_n_q  <= 1'b1;
            wr_en_q       <= 1'b0;
            wr_row_q      <= 5'd0;
            wr_col_q      <= 7'd0;
            wr_char_q     <= 8'd0;
            cur_row_q     <= 5'd0;
            cur_col_q     <= 7'd0;
            key_down_q    <= 1'b0;
            last_code_q   <= 8'd0;
            press_count_q <= 8'd0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            code_q        <= code_d;
            brk_q         <= brk_d;
            ext_q         <= ext_d;
            nextdata_n_q  <= nextdata_n_d;
            wr_en_q       <= wr_en_d;
            wr_row_q      <= wr_row_d;
            wr_col_q      <= wr_col_d;
            wr_char_q     <= wr_char_d;
            cur_row_q     <= cur_row_d;
            cur_col_q     <= cur_col_d;
            key_down_q    <= key_down_d;
            last_code_q   <= last_code_d;
            press_count_q <= press_count_d;
            overflow_q    <= overflow_d;
        end
    end

    assign ps2_nextdata_n = nextdata_n_q;
    assign scan_code      = code_q;
    assign wr_en          = wr_en_q;
    assign wr_row         = wr_row_q;
    assign wr_col         = wr_col_q;
    assign wr_char        = wr_char_q;
    assign cur_row        = cur_row_q;
    assign cur_col        = cur_col_q;
    assign key_down       = key_down_q;
    assign last_code      = last_code_q;
    assign press_count    = press_count_q;
    assign overflow_seen  = overflow_q;

endmodule

// File: tb/tb_kbd_text_ctrl.sv
// Directed bench for kbd_text_ctrl: a table of single-byte vectors with
// hand-computed results, plus hand-written wrap, edit and reset sequences.
module tb_kbd_text_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] ps2_data = 8'd0;
    logic       ps2_ready = 1'b0;
    logic       ps2_overflow = 1'b0;
    logic       ps2_nextdata_n;
    logic [7:0] scan_code;
    logic [7:0] ascii_in;
    logic       wr_en;
    logic [4:0] wr_row;
    logic [6:0] wr_col;
    logic [7:0] wr_char;
    logic [4:0] cur_row;
    logic [6:0] cur_col;
    logic       key_down;
    logic [7:0] last_code;
    logic [7:0] press_count;
    logic       overflow_seen;

    kbd_text_ctrl #(.COLS(70), .ROWS(30)) dut (
        .clk(clk), .rst(rst), .ps2_data(ps2_data), .ps2_ready(ps2_ready),
        .ps2_overflow(ps2_overflow), .ps2_nextdata_n(ps2_nextdata_n),
        .scan_code(scan_code), .ascii_in(ascii_in), .wr_en(wr_en),
        .wr_row(wr_row), .wr_col(wr_col), .wr_char(wr_char),
        .cur_row(cur_row), .cur_col(cur_col), .key_down(key_down),
        .last_code(last_code), .press_count(press_count),
        .overflow_seen(overflow_seen)
    );

    always #5 clk = ~clk;

    // External ASCII lookup stand-in: a few printable keys, everything else 0.
    always_comb begin
        case (scan_code)
            8'h1C:   ascii_in = 8'h61;
            8'h32:   ascii_in = 8'h62;
            8'h21:   ascii_in = 8'h63;
            default: ascii_in = 8'h00;
        endcase
    end

    int n_vec = 0;
    int n_bad = 0;
    int pops, wrs, wr_k, wr_total;
    logic [4:0] w_row;
    logic [6:0] w_col;
    logic [7:0] w_char;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Present one byte as the FIFO head, pop it on the DUT's strobe, and
    // watch five edges for pops and writes.
    task automatic send_byte(input logic [7:0] code, input logic ovf);
        pops = 0;
        wrs  = 0;
        wr_k = -1;
        @(negedge clk);
        ps2_data     = code;
        ps2_ready    = 1'b1;
        ps2_overflow = ovf;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            if (k == 0) ps2_overflow = 1'b0;
            if (!ps2_nextdata_n) pops++;
            if (wr_en) begin
                wrs++;
                wr_total++;
                wr_k   = k;
                w_row  = wr_row;
                w_col  = wr_col;
                w_char = wr_char;
            end
            if (k == 1) ps2_ready = 1'b0;   // FIFO advanced on the pop edge
        end
    endtask

    typedef struct {
        logic       rst_before;
        logic [7:0] code;
        logic       exp_wr;
        logic [4:0] wrow;
        logic [6:0] wcol;
        logic [7:0] wchar;
        logic [4:0] crow;
        logic [6:0] ccol;
        logic       kd;
        logic [7:0] last;
        logic [7:0] cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic [7:0] c, input logic w,
                                input logic [4:0] wr, input logic [6:0] wc, input logic [7:0] wch,
                                input logic [4:0] cr, input logic [6:0] cc, input logic kd,
                                input logic [7:0] l, input logic [7:0] n);
        vec_t v;
        v.rst_before = r; v.code = c; v.exp_wr = w; v.wrow = wr; v.wcol = wc;
        v.wchar = wch; v.crow = cr; v.ccol = cc; v.kd = kd; v.last = l; v.cnt = n;
        return v;
    endfunction

    initial begin
        // press / release A
        vecs.push_back(mk(1'b1, 8'h1C, 1'b1, 5'd0, 7'd0, 8'h61, 5'd0, 7'd1, 1'b1, 8'h1C, 8'd1));
        vecs.push_back(mk(1'b0, 8'hF0, 1'b0, 5'd0, 7'd0, 8'h00, 5'd0, 7'd1, 1'b1, 8'h1C, 8'd1));
        vecs.push_back(mk(1'b0, 8'h1C, 1'b0, 5'd0, 7'd0, 8'h00, 5'd0, 7'd1, 1'b0, 8'h1C, 8'd1));
        // typematic
        vecs.push_back(mk(1'b1, 8'h1C, 1'b1, 5'd0, 7'd0, 8'h61, 5'd0, 7'd1, 1'b1, 8'h1C, 8'd1));
        vecs.push_back(mk(1'b0, 8'h1C, 1'b1, 5'd0, 7'd1, 8'h61, 5'd0, 7'd2, 1'b1, 8'h1C, 8'd1));
        vecs.push_back(mk(1'b0, 8'h1C, 1'b1, 5'd0, 7'd2, 8'h61, 5'd0, 7'd3, 1'b1, 8'h1C, 8'd1));
        vecs.push_back(mk(1'b0, 8'hF0, 1'b0, 5'd0, 7'd0, 8'h00, 5'd0, 7'd3, 1'b1, 8'h1C, 8'd1));
        vecs.push_back(mk(1'b0, 8'h1C, 1'b0, 5'd0, 7'd0, 8'h00, 5'd0, 7'd3, 1'b0, 8'h1C, 8'd1));
        // extended key E0 75 / E0 F0 75, then a plain printable
        vecs.push_back(mk(1'b0, 8'hE0, 1'b0, 5'd0, 7'd0, 8'h00, 5'd0, 7'd3, 1'b0, 8'h1C, 8'd1));
        vecs.push_back(mk(1'b0, 8'h75, 1'b0, 5'd0, 7'd0, 8'h00, 5'd0, 7'd3, 1'b1, 8'h75, 8'd2));
        vecs.push_back(mk(1'b0, 8'hE0, 1'b0, 5'd0, 7'd0, 8'h00, 5'd0, 7'd3, 1'b1, 8'h75, 8'd2));
        vecs.push_back(mk(1'b0, 8'hF0, 1'b0, 5'd0, 7'd0, 8'h00, 5'd0, 7'd3, 1'b1, 8'h75, 8'd2));
        vecs.push_back(mk(1'b0, 8'h75, 1'b0, 5'd0, 7'd0, 8'h00, 5'd0, 7'd3, 1'b0, 8'h75, 8'd2));
        vecs.push_back(mk(1'b0, 8'h32, 1'b1, 5'd0, 7'd3, 8'h62, 5'd0, 7'd4, 1'b1, 8'h32, 8'd3));
        // edit keys: backspace at (0,0), enter, backspace across a row
        vecs.push_back(mk(1'b1, 8'h66, 1'b1, 5'd0, 7'd0, 8'h20, 5'd0, 7'd0, 1'b1, 8'h66, 8'd1));
        vecs.push_back(mk(1'b0, 8'hF0, 1'b0, 5'd0, 7'd0, 8'h00, 5'd0, 7'd0, 1'b1, 8'h66, 8'd1));
        vecs.push_back(mk(1'b0, 8'h66, 1'b0, 5'd0, 7'd0, 8'h00, 5'd0, 7'd0, 1'b0, 8'h66, 8'd1));
        vecs.push_back(mk(1'b0, 8'h5A, 1'b0, 5'd0, 7'd0, 8'h00, 5'd1, 7'd0, 1'b1, 8'h5A, 8'd2));
        vecs.push_back(mk(1'b0, 8'hF0, 1'b0, 5'd0, 7'd0, 8'h00, 5'd1, 7'd0, 1'b1, 8'h5A, 8'd2));
        vecs.push_back(mk(1'b0, 8'h5A, 1'b0, 5'd0, 7'd0, 8'h00, 5'd1, 7'd0, 1'b0, 8'h5A, 8'd2));
        vecs.push_back(mk(1'b0, 8'h66, 1'b1, 5'd0, 7'd69, 8'h20, 5'd0, 7'd69, 1'b1, 8'h66, 8'd3));
        vecs.push_back(mk(1'b0, 8'h32, 1'b1, 5'd0, 7'd69, 8'h62, 5'd1, 7'd0, 1'b1, 8'h32, 8'd4));
        vecs.push_back(mk(1'b0, 8'h76, 1'b0, 5'd0, 7'd0, 8'h00, 5'd1, 7'd0, 1'b1, 8'h76, 8'd5));

        wr_total = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_nextdata_n", 32'(ps2_nextdata_n), 32'd1);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_scan_code", 32'(scan_code), 32'd0);
        chk("rst_cursor", {20'd0, cur_row, cur_col}, 32'd0);
        chk("rst_wr_addr_char", {12'd0, wr_row, wr_col, wr_char}, 32'd0);
        chk("rst_key_down", 32'(key_down), 32'd0);
        chk("rst_last_code", 32'(last_code), 32'd0);
        chk("rst_press_count", 32'(press_count), 32'd0);
        chk("rst_overflow_seen", 32'(overflow_seen), 32'd0);

        // table-driven single-byte vectors
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst_before) do_reset();
            send_byte(vecs[i].code, 1'b0);
            chk($sformatf("v%0d_pops", i), 32'(pops), 32'd1);
            chk($sformatf("v%0d_scan_code", i), 32'(scan_code), 32'(vecs[i].code));
            chk($sformatf("v%0d_writes", i), 32'(wrs), vecs[i].exp_wr ? 32'd1 : 32'd0);
            if (vecs[i].exp_wr) begin
                chk($sformatf("v%0d_wr_latency", i), 32'(wr_k), 32'd2);
                chk($sformatf("v%0d_wr_pos", i), 32'({w_row, w_col}), 32'({vecs[i].wrow, vecs[i].wcol}));
                chk($sformatf("v%0d_wr_char", i), 32'(w_char), 32'(vecs[i].wchar));
            end
            chk($sformatf("v%0d_cursor", i), 32'({cur_row, cur_col}), 32'({vecs[i].crow, vecs[i].ccol}));
            chk($sformatf("v%0d_key_down", i), 32'(key_down), 32'(vecs[i].kd));
            chk($sformatf("v%0d_last_code", i), 32'(last_code), 32'(vecs[i].last));
            chk($sformatf("v%0d_press_count", i), 32'(press_count), 32'(vecs[i].cnt));
        end

        // column wrap: 70 press/release pairs, then write 71 lands at (1,0)
        do_reset();
        wr_total = 0;
        for (int i = 0; i < 70; i++) begin
            send_byte(8'h1C, 1'b0);
            send_byte(8'hF0, 1'b0);
            send_byte(8'h1C, 1'b0);
        end
        chk("wrap70_writes", 32'(wr_total), 32'd70);
        chk("wrap70_cursor", 32'({cur_row, cur_col}), 32'({5'd1, 7'd0}));
        chk("wrap70_press_count", 32'(press_count), 32'd70);
        send_byte(8'h1C, 1'b0);
        chk("wrap71_pos", 32'({w_row, w_col}), 32'({5'd1, 7'd0}));
        chk("wrap71_cursor", 32'({cur_row, cur_col}), 32'({5'd1, 7'd1}));
        chk("wrap71_press_count", 32'(press_count), 32'd71);

        // row wrap: 29 enters, 69 typed chars, then the last cell wraps to (0,0)
        do_reset();
        for (int i = 0; i < 29; i++) begin
            send_byte(8'h5A, 1'b0);
            send_byte(8'hF0, 1'b0);
            send_byte(8'h5A, 1'b0);
        end
        chk("rowwrap_enter29", 32'({cur_row, cur_col}), 32'({5'd29, 7'd0}));
        for (int i = 0; i < 69; i++) send_byte(8'h21, 1'b0);
        chk("rowwrap_preset", 32'({cur_row, cur_col}), 32'({5'd29, 7'd69}));
        send_byte(8'h21, 1'b0);
        chk("rowwrap_last_pos", 32'({w_row, w_col}), 32'({5'd29, 7'd69}));
        chk("rowwrap_last_char", 32'(w_char), 32'h63);
        chk("rowwrap_cursor", 32'({cur_row, cur_col}), 32'd0);

        // enter at (2,5): cursor to (3,0) with no write
        do_reset();
        send_byte(8'h5A, 1'b0);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h5A, 1'b0);
        send_byte(8'h5A, 1'b0);
        for (int i = 0; i < 5; i++) send_byte(8'h21, 1'b0);
        chk("enter_preset", 32'({cur_row, cur_col}), 32'({5'd2, 7'd5}));
        send_byte(8'h5A, 1'b0);
        chk("enter_no_write", 32'(wrs), 32'd0);
        chk("enter_cursor", 32'({cur_row, cur_col}), 32'({5'd3, 7'd0}));

        // overflow with a byte in the same cycle, then reset during POP
        do_reset();
        send_byte(8'h1C, 1'b0);
        send_byte(8'hE0, 1'b1);
        chk("ovf_same_cycle_flag", 32'(overflow_seen), 32'd1);
        chk("ovf_same_cycle_pops", 32'(pops), 32'd1);
        chk("ovf_same_cycle_capture", 32'(scan_code), 32'hE0);
        send_byte(8'hF0, 1'b0);
        @(negedge clk);
        ps2_data  = 8'h1C;
        ps2_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("pop_before_reset", 32'(ps2_nextdata_n), 32'd0);
        rst = 1'b1;
        #1;
        chk("midrst_nextdata_n", 32'(ps2_nextdata_n), 32'd1);
        chk("midrst_wr_en", 32'(wr_en), 32'd0);
        chk("midrst_scan_code", 32'(scan_code), 32'd0);
        chk("midrst_cursor", 32'({cur_row, cur_col}), 32'd0);
        chk("midrst_counts", 32'({key_down, last_code, press_count}), 32'd0);
        chk("midrst_overflow_seen", 32'(overflow_seen), 32'd0);
        ps2_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        wrs = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            if (wr_en) wrs++;
        end
        chk("midrst_no_write", 32'(wrs), 32'd0);
        send_byte(8'h1C, 1'b0);
        chk("post_rst_make_write", 32'(wrs), 32'd1);
        chk("post_rst_make_pos", 32'({w_row, w_col}), 32'd0);
        chk("post_rst_make_count", 32'(press_count), 32'd1);
        chk("post_rst_key_down", 32'(key_down), 32'd1);
        @(negedge clk);
        ps2_overflow = 1'b1;
        @(negedge clk);
        ps2_overflow = 1'b0;
        repeat (2) @(negedge clk);
        chk("ovf_sticky", 32'(overflow_seen), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
